// File: rtl/dm_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
package dm_arb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 16;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

endpackage

// File: rtl/dm_port_arbiter_if.sv
// Requester and memory bundle of the data-memory arbiter.
// master: requesters plus the memory model; slave: the arbiter.
interface dm_port_arbiter_if #(
  parameter int AW = dm_arb_pkg::ADDR_W,
  parameter int DW = dm_arb_pkg::DATA_W
);
  logic          p0_req;
  logic          p0_we;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata;
  logic          p0_gnt;
  logic          p0_done;
  logic [DW-1:0] p0_rdata;

  logic          p1_req;
  logic          p1_we;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p1_gnt;
  logic          p1_done;
  logic [DW-1:0] p1_rdata;

  logic          cpu_stall;

  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_read;
  logic          mem_write;
  logic [DW-1:0] mem_rdata;

  modport master (
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_gnt, p0_done, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_gnt, p1_done, p1_rdata,
    input  cpu_stall,
    input  mem_addr, mem_wdata, mem_read, mem_write,
    output mem_rdata
  );

  modport slave (
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_gnt, p0_done, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_gnt, p1_done, p1_rdata,
    output cpu_stall,
    output mem_addr, mem_wdata, mem_read, mem_write,
    input  mem_rdata
  );

endinterface

// File: rtl/dm_port_arbiter_pick.sv
// Two-way request picker: a lone request wins; a tie goes to the debug
// port when fixed priority is set, otherwise to the port not served last.
module dm_arb_pick
  import dm_arb_pkg::*;
(
  input  logic i_req0,
  input  logic i_req1,
  input  logic i_last,
  input  logic i_fixed,
  output logic o_sel,
  output logic o_any
);

  // Select winner from current requests and last-served port.
  always_comb begin
    o_any = i_req0 | i_req1;
    o_sel = PORT_CPU;
    if (i_req0 && i_req1) begin
      o_sel = i_fixed ? PORT_DBG : ~i_last;
    end else if (i_req1) begin
      o_sel = PORT_DBG;
    end
  end

endmodule

// File: rtl/dm_port_arbiter.sv
// Arbitrates the single-ported data memory between the CPU port (0) and the
// loader/debug port (1). One access per three cycles: latch, strobe, respond.
//
// state  | meaning
// IDLE   | sample requests, latch the winner's command
// ACCESS | memory strobed for one cycle, gnt high, read data captured
// RESP   | done pulse to the served port, strobes low
module dm_port_arbiter
  import dm_arb_pkg::*;
#(
  parameter int AW        = ADDR_W,
  parameter int DW        = DATA_W,
  parameter bit DBG_FIXED = 1'b0
) (
  input logic            clk,
  input logic            rst,
  dm_port_arbiter_if.slave bus
);

  state_t        r_state;
  logic          r_last;
  logic          r_sel;
  logic          r_we;
  logic          r_gnt0;
  logic          r_gnt1;
  logic          r_done0;
  logic          r_done1;
  logic [DW-1:0] r_p0_rdata;
  logic [DW-1:0] r_p1_rdata;
  logic [AW-1:0] r_mem_addr;
  logic [DW-1:0] r_mem_wdata;
  logic          r_mem_read;
  logic          r_mem_write;

  logic          w_sel;
  logic          w_any;
  logic          w_we;

  dm_arb_pick u_pick (
    .i_req0  (bus.p0_req),
    .i_req1  (bus.p1_req),
    .i_last  (r_last),
    .i_fixed (DBG_FIXED),
    .o_sel   (w_sel),
    .o_any   (w_any)
  );

  assign w_we = w_sel ? bus.p1_we : bus.p0_we;

  // Arbitration FSM; every output is registered so the strobes and gnt
  // are already valid for the whole ACCESS cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state     <= IDLE;
      r_last      <= PORT_DBG;
      r_sel       <= PORT_CPU;
      r_we        <= 1'b0;
      r_gnt0      <= 1'b0;
      r_gnt1      <= 1'b0;
      r_done0     <= 1'b0;
      r_done1     <= 1'b0;
      r_p0_rdata  <= '0;
      r_p1_rdata  <= '0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_any) begin
            r_sel       <= w_sel;
            r_we        <= w_we;
            r_mem_addr  <= w_sel ? bus.p1_addr : bus.p0_addr;
            r_mem_wdata <= w_sel ? bus.p1_wdata : bus.p0_wdata;
            r_mem_read  <= ~w_we;
            r_mem_write <= w_we;
            r_gnt0      <= (w_sel == PORT_CPU);
            r_gnt1      <= (w_sel == PORT_DBG);
            r_state     <= ACCESS;
          end
        end
        ACCESS: begin
          // Writes leave the port's read register untouched.
          if (!r_we) begin
            if (r_sel == PORT_DBG) r_p1_rdata <= bus.mem_rdata;
            else                   r_p0_rdata <= bus.mem_rdata;
          end
          r_last      <= r_sel;
          r_gnt0      <= 1'b0;
          r_gnt1      <= 1'b0;
          r_mem_read  <= 1'b0;
          r_mem_write <= 1'b0;
          r_done0     <= (r_sel == PORT_CPU);
          r_done1     <= (r_sel == PORT_DBG);
          r_state     <= RESP;
        end
        RESP: begin
          r_done0 <= 1'b0;
          r_done1 <= 1'b0;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.p0_gnt    = r_gnt0;
  assign bus.p1_gnt    = r_gnt1;
  assign bus.p0_done   = r_done0;
  assign bus.p1_done   = r_done1;
  assign bus.p0_rdata  = r_p0_rdata;
  assign bus.p1_rdata  = r_p1_rdata;
  assign bus.mem_addr  = r_mem_addr;
  assign bus.mem_wdata = r_mem_wdata;
  assign bus.mem_read  = r_mem_read;
  assign bus.mem_write = r_mem_write;

  // Stall is released in the same cycle the CPU sees done.
  assign bus.cpu_stall = bus.p0_req & ~r_done0;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Directed bench for dm_port_arbiter: a round-robin instance (a) and a
// fixed-priority instance (b), each with its own small memory model.
module tb_dm_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;

  int n_err = 0;
  int n_chk = 0;

  dm_port_arbiter_if ifa ();
  dm_port_arbiter_if ifb ();

  dm_port_arbiter #(.AW(16), .DW(16), .DBG_FIXED(1'b0)) dut_a (
    .clk (clk),
    .rst (rst),
    .bus (ifa.slave)
  );

  dm_port_arbiter #(.AW(16), .DW(16), .DBG_FIXED(1'b1)) dut_b (
    .clk (clk),
    .rst (rst),
    .bus (ifb.slave)
  );

  always #5 clk = ~clk;

  // Memory: preset contents unless the location has been written.
  logic [15:0]  mem_a [256];
  logic [255:0] wr_a;

  function automatic logic [15:0] preset(input logic [7:0] a);
    case (a)
      8'h10:   return 16'hBEEF;
      8'h30:   return 16'h3333;
      default: return {8'hA5, a};
    endcase
  endfunction

  always @(posedge clk) begin
    if (!rst) wr_a <= '0;
    else if (ifa.mem_write) begin
      mem_a[ifa.mem_addr[7:0]] <= ifa.mem_wdata;
      wr_a[ifa.mem_addr[7:0]]  <= 1'b1;
    end
  end

  assign ifa.mem_rdata = wr_a[ifa.mem_addr[7:0]] ? mem_a[ifa.mem_addr[7:0]]
                                                 : preset(ifa.mem_addr[7:0]);
  assign ifb.mem_rdata = preset(ifb.mem_addr[7:0]);

  task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_req(input bit use_b, input logic port, input logic val);
    if (use_b) begin
      if (port) ifb.p1_req = val; else ifb.p0_req = val;
    end else begin
      if (port) ifa.p1_req = val; else ifa.p0_req = val;
    end
  endtask

  // Step until a grant appears (bounded); report winner and cycles waited.
  task automatic wait_grant(input bit use_b, input string tag, output logic who, output int n);
    logic g0, g1;
    n = 0;
    do begin
      tick();
      n++;
      g0 = use_b ? ifb.p0_gnt : ifa.p0_gnt;
      g1 = use_b ? ifb.p1_gnt : ifa.p1_gnt;
    end while (!(g0 | g1) && n < 8);
    check_val({tag, "_gnt_onehot"}, {30'd0, g0, g1} == 32'd1 || {30'd0, g0, g1} == 32'd2, 1);
    who = g1;
  endtask

  // Both ports start requesting; the winner drops req in ACCESS and
  // re-raises it in RESP when its rearm bit is set.
  task automatic run_rounds(input bit use_b, input string tag, input logic [2:0] exp_who,
                            input logic [2:0] rearm);
    logic who;
    int   n;
    int   exp_lat;
    set_req(use_b, 1'b0, 1'b1);
    set_req(use_b, 1'b1, 1'b1);
    for (int k = 0; k < 3; k++) begin
      exp_lat = (k == 0) ? 1 : 2;
      wait_grant(use_b, $sformatf("%s%0d", tag, k), who, n);
      check_val($sformatf("%s%0d_who", tag, k), who, exp_who[k]);
      check_val($sformatf("%s%0d_lat", tag, k), n, exp_lat);
      set_req(use_b, who, 1'b0);
      tick();
      check_val($sformatf("%s%0d_done", tag, k),
                use_b ? (who ? ifb.p1_done : ifb.p0_done) : (who ? ifa.p1_done : ifa.p0_done), 1);
      set_req(use_b, who, rearm[k]);
    end
    set_req(use_b, 1'b0, 1'b0);
    set_req(use_b, 1'b1, 1'b0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic who;
    int   n;
    ifa.p0_req = 0; ifa.p0_we = 0; ifa.p0_addr = '0; ifa.p0_wdata = '0;
    ifa.p1_req = 0; ifa.p1_we = 0; ifa.p1_addr = '0; ifa.p1_wdata = '0;
    ifb.p0_req = 0; ifb.p0_we = 0; ifb.p0_addr = '0; ifb.p0_wdata = '0;
    ifb.p1_req = 0; ifb.p1_we = 0; ifb.p1_addr = '0; ifb.p1_wdata = '0;

    // Reset
    rst = 1'b0;
    repeat (2) tick();
    check_val("rst_gnt",    {ifa.p0_gnt, ifa.p1_gnt}, 0);
    check_val("rst_done",   {ifa.p0_done, ifa.p1_done}, 0);
    check_val("rst_strobe", {ifa.mem_read, ifa.mem_write}, 0);
    check_val("rst_addr",   ifa.mem_addr, 0);
    check_val("rst_wdata",  ifa.mem_wdata, 0);
    check_val("rst_rdata",  {ifa.p0_rdata, ifa.p1_rdata}, 0);
    check_val("rst_stall",  ifa.cpu_stall, 0);
    rst = 1'b1;
    tick();

    // Single CPU read
    ifa.p0_addr = 16'h0010; ifa.p0_we = 1'b0; ifa.p0_req = 1'b1;
    #1 check_val("rd_stall_T", ifa.cpu_stall, 1);
    tick();
    check_val("rd_gnt",      {ifa.p0_gnt, ifa.p1_gnt}, 2'b10);
    check_val("rd_mem_read", {ifa.mem_read, ifa.mem_write}, 2'b10);
    check_val("rd_mem_addr", ifa.mem_addr, 16'h0010);
    check_val("rd_stall_T1", ifa.cpu_stall, 1);
    ifa.p0_req = 1'b0;
    tick();
    check_val("rd_done",   {ifa.p0_done, ifa.p1_done, ifa.p0_gnt}, 3'b100);
    check_val("rd_rdata",  ifa.p0_rdata, 16'hBEEF);
    check_val("rd_strobe", {ifa.mem_read, ifa.mem_write}, 0);
    check_val("rd_stall_T2", ifa.cpu_stall, 0);
    tick();
    check_val("rd_done_clr", ifa.p0_done, 0);

    // Round-robin ties from a fresh reset: p0, then p1, then p0
    rst = 1'b0; tick(); rst = 1'b1; tick();
    ifa.p0_addr = 16'h0010; ifa.p1_addr = 16'h0030; ifa.p1_we = 1'b0;
    run_rounds(1'b0, "rr", 3'b010, 3'b011);
    check_val("rr_p1_rdata", ifa.p1_rdata, 16'h3333);
    check_val("rr_p0_rdata", ifa.p0_rdata, 16'hBEEF);

    // Fixed priority: p1 wins while it asks, p0 only once p1 stops
    ifb.p0_addr = 16'h0040; ifb.p1_addr = 16'h0050;
    run_rounds(1'b1, "fx", 3'b011, 3'b001);
    check_val("fx_p0_rdata", ifb.p0_rdata, 16'hA540);
    check_val("fx_p1_rdata", ifb.p1_rdata, 16'hA550);

    // Loader write then CPU read-back
    ifa.p1_addr = 16'h0020; ifa.p1_wdata = 16'h1234; ifa.p1_we = 1'b1; ifa.p1_req = 1'b1;
    #1 check_val("wr_idle_strobe", ifa.mem_write, 0);
    wait_grant(1'b0, "wr", who, n);
    check_val("wr_who",    who, 1);
    check_val("wr_strobe", {ifa.mem_read, ifa.mem_write}, 2'b01);
    check_val("wr_addr",   ifa.mem_addr, 16'h0020);
    check_val("wr_wdata",  ifa.mem_wdata, 16'h1234);
    ifa.p1_req = 1'b0; ifa.p1_we = 1'b0;
    tick();
    check_val("wr_strobe_off", {ifa.mem_read, ifa.mem_write}, 0);
    check_val("wr_done",       {ifa.p0_done, ifa.p1_done}, 2'b01);
    check_val("wr_rdata_hold", ifa.p1_rdata, 16'h3333);
    tick();
    ifa.p0_addr = 16'h0020; ifa.p0_we = 1'b0; ifa.p0_req = 1'b1;
    wait_grant(1'b0, "rb", who, n);
    check_val("rb_who", who, 0);
    ifa.p0_req = 1'b0;
    tick();
    check_val("rb_rdata", ifa.p0_rdata, 16'h1234);
    tick();

    // Reset during ACCESS drops the access; re-presented request completes
    ifa.p0_addr = 16'h0010; ifa.p0_req = 1'b1;
    wait_grant(1'b0, "ra", who, n);
    check_val("ra_who", who, 0);
    rst = 1'b0;
    tick();
    check_val("ra_done",   {ifa.p0_done, ifa.p1_done}, 0);
    check_val("ra_strobe", {ifa.mem_read, ifa.mem_write, ifa.p0_gnt}, 0);
    check_val("ra_rdata",  ifa.p0_rdata, 0);
    check_val("ra_stall",  ifa.cpu_stall, 1);
    rst = 1'b1;
    wait_grant(1'b0, "ra2", who, n);
    check_val("ra2_lat",  n, 1);
    check_val("ra2_addr", ifa.mem_addr, 16'h0010);
    ifa.p0_req = 1'b0;
    tick();
    check_val("ra2_done",  ifa.p0_done, 1);
    check_val("ra2_rdata", ifa.p0_rdata, 16'hBEEF);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
